// File: rtl/btn_press_classifier.sv
// Per-channel button debouncer and short/long/auto-repeat press classifier.
// Auto-repeat is built only when the AUTO_REPEAT_EN macro is defined.
module btn_press_classifier #(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 200,
  parameter int LONG_CYCLES   = 10000,
  parameter int REPEAT_CYCLES = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] db_level,
  output logic [N_BTN-1:0] short_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int DW = $clog2(DB_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] LONG_FULL = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD
  } state_t;

  if (N_BTN < 1 || N_BTN > 16 || DB_CYCLES < 1 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("btn_press_classifier: parameter out of range");
  end

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic            r_db;
    logic [DW-1:0]   r_db_cnt;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_nxt;
    logic            r_short;
    logic            r_long;
    logic            w_short_nxt;
    logic            w_long_nxt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_db     <= 1'b0;
        r_db_cnt <= '0;
        r_state  <= ST_IDLE;
        r_hold   <= '0;
        r_short  <= 1'b0;
        r_long   <= 1'b0;
      end else begin
        if (r_sync2[g] != r_db) begin
          if (r_db_cnt == DB_LAST) begin
            r_db     <= ~r_db;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
          end
        end else begin
          r_db_cnt <= '0;
        end
        r_state <= w_state_nxt;
        r_hold  <= w_hold_nxt;
        r_short <= w_short_nxt;
        r_long  <= w_long_nxt;
      end
    end

    // long_pulse is registered one cycle early so it is high exactly while
    // the hold counter equals LONG_CYCLES; that cycle then never yields a
    // short pulse, even if the button is released in it.
    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_short_nxt = 1'b0;
      w_long_nxt  = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_db) begin
            w_state_nxt = ST_PRESSED;
            w_hold_nxt  = HW'(1);
          end
        end
        ST_PRESSED: begin
          if (r_hold == LONG_FULL) begin
            w_state_nxt = r_db ? ST_LONG_HELD : ST_IDLE;
            if (!r_db) w_hold_nxt = '0;
          end else if (r_db) begin
            w_hold_nxt = r_hold + HW'(1);
            w_long_nxt = (r_hold == LONG_LAST);
          end else begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
            w_short_nxt = 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (!r_db) begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
        end
      endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] r_rep_cnt;
    logic          r_rep;
    logic          w_rep_phase;

    // Counting starts in the long_pulse cycle so the first repeat lands
    // exactly REPEAT_CYCLES after it.
    assign w_rep_phase = r_db && ((r_state == ST_LONG_HELD) ||
                                  (r_state == ST_PRESSED && r_hold == LONG_FULL));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rep_cnt <= '0;
        r_rep     <= 1'b0;
      end else if (w_rep_phase) begin
        r_rep     <= (r_rep_cnt == REP_LAST);
        r_rep_cnt <= (r_rep_cnt == REP_LAST) ? '0 : r_rep_cnt + RW'(1);
      end else begin
        r_rep     <= 1'b0;
        r_rep_cnt <= '0;
      end
    end

    assign repeat_pulse[g] = r_rep;
`else
    assign repeat_pulse[g] = 1'b0;
`endif

    assign db_level[g]    = r_db;
    assign short_pulse[g] = r_short;
    assign long_pulse[g]  = r_long;
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier (N_BTN=2, DB=4, LONG=20, REPEAT=5).
// Expectations follow AUTO_REPEAT_EN when that macro is defined.
module tb_btn_press_classifier;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] db_level;
  logic [1:0] short_pulse;
  logic [1:0] long_pulse;
  logic [1:0] repeat_pulse;

  always #5 clk = ~clk;

  btn_press_classifier #(
    .N_BTN        (2),
    .DB_CYCLES    (4),
    .LONG_CYCLES  (20),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .db_level    (db_level),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int rise_c[2], fall_c[2], short_c[2], long_c[2];
  int n_short[2], n_long[2], n_rep[2];
  int rep_at[8];
  int both_c;
  logic [1:0] db_prev;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc    = 0;
    both_c = -1;
    for (int c = 0; c < 2; c++) begin
      rise_c[c] = -1; fall_c[c] = -1; short_c[c] = -1; long_c[c] = -1;
      n_short[c] = 0; n_long[c] = 0; n_rep[c] = 0;
    end
    for (int k = 0; k < 8; k++) rep_at[k] = -1;
    db_prev = db_level;
  endtask

  // Advance n cycles; stats are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < 2; c++) begin
        if (db_level[c] && !db_prev[c] && rise_c[c] < 0) rise_c[c] = cyc;
        if (!db_level[c] && db_prev[c] && fall_c[c] < 0) fall_c[c] = cyc;
        if (short_pulse[c]) begin
          n_short[c]++;
          if (short_c[c] < 0) short_c[c] = cyc;
        end
        if (long_pulse[c]) begin
          n_long[c]++;
          if (long_c[c] < 0) long_c[c] = cyc;
        end
        if (repeat_pulse[c]) begin
          if (c == 1 && n_rep[1] < 8) rep_at[n_rep[1]] = cyc;
          n_rep[c]++;
        end
      end
      if (short_pulse == 2'b11 && both_c < 0) both_c = cyc;
      db_prev = db_level;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_db"},  int'(db_level),     0);
    chk({tag, "_sp"},  int'(short_pulse),  0);
    chk({tag, "_lp"},  int'(long_pulse),   0);
    chk({tag, "_rp"},  int'(repeat_pulse), 0);
  endtask

  initial begin
    btn_in = 2'b00;
    rst    = 1'b1;
    #1;
    chk_all_zero("rst0");
    // Buttons pressed while reset is held must not propagate
    btn_in = 2'b11;
    tick(8);
    chk_all_zero("rst_hold");
    btn_in = 2'b00;
    tick(3);
    rst = 1'b0;
    tick(3);

    // S1: 3-cycle glitch is rejected
    clear_stats();
    btn_in = 2'b01;
    tick(3);
    btn_in = 2'b00;
    tick(20);
    chk("s1_rise",  rise_c[0],  -1);
    chk("s1_short", n_short[0], 0);
    chk("s1_long",  n_long[0],  0);

    // S2: short press on channel 0
    clear_stats();
    btn_in = 2'b01;
    tick(12);
    btn_in = 2'b00;
    tick(20);
    chk("s2_rise",    rise_c[0],  6);
    chk("s2_fall",    fall_c[0],  18);
    chk("s2_short_n", n_short[0], 1);
    chk("s2_short_t", short_c[0], 19);
    chk("s2_long",    n_long[0],  0);
    chk("s2_ch1",     n_short[1], 0);

    // S3/S4: long hold on channel 1
    clear_stats();
    btn_in = 2'b10;
    tick(40);
    btn_in = 2'b00;
    tick(20);
    chk("s3_rise",   rise_c[1],  6);
    chk("s3_long_t", long_c[1],  26);
    chk("s3_long_n", n_long[1],  1);
    chk("s3_short",  n_short[1], 0);
    chk("s3_fall",   fall_c[1],  46);
`ifdef AUTO_REPEAT_EN
    chk("s3_rep_n",  n_rep[1],  4);
    chk("s3_rep0",   rep_at[0], 31);
    chk("s3_rep1",   rep_at[1], 36);
    chk("s3_rep2",   rep_at[2], 41);
    chk("s3_rep3",   rep_at[3], 46);
`else
    chk("s4_rep_n",  n_rep[1],  0);
`endif
    chk("s3_rep_ch0", n_rep[0], 0);

    // S5: simultaneous short press on both channels
    clear_stats();
    btn_in = 2'b11;
    tick(10);
    btn_in = 2'b00;
    tick(20);
    chk("s5_both_t", both_c,     17);
    chk("s5_short0", n_short[0], 1);
    chk("s5_short1", n_short[1], 1);
    chk("s5_long",   n_long[0] + n_long[1], 0);

    // S6: reset 10 cycles into a long hold, button kept high
    clear_stats();
    btn_in = 2'b10;
    tick(16);
    chk("s6_pre_rise", rise_c[1], 6);
    rst = 1'b1;
    #1;
    chk_all_zero("s6_rst");
    tick(3);
    chk_all_zero("s6_rst3");
    chk("s6_abort_l", n_long[1],  0);
    chk("s6_abort_s", n_short[1], 0);
    rst = 1'b0;
    clear_stats();
    tick(30);
    chk("s6_rise",   rise_c[1], 6);
    chk("s6_long_t", long_c[1], 26);
    btn_in = 2'b00;
    tick(20);
    chk("s6_long_n", n_long[1],  1);
    chk("s6_short",  n_short[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
